// File: rtl/memory_game_ctrl.sv
// Round controller for the memorization game: shows a random BCD target, collects
// keypad digits, compares them and tracks score, lives and the per-round digit count.
module memory_game_ctrl #(
  parameter int DIGITS_MAX    = 8,
  parameter int DIGITS_START  = 4,
  parameter int SHOW_TICKS    = 3,
  parameter int ENTRY_TIMEOUT = 20,
  parameter int LIVES         = 3,
  localparam int LW = $clog2(DIGITS_MAX + 1),
  localparam int W  = 4 * DIGITS_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic [W-1:0]  rand_in,
  input  logic          key_valid,
  input  logic [3:0]    key_digit,
  output logic [W-1:0]  show_value,
  output logic [LW-1:0] show_len,
  output logic [LW-1:0] entry_cnt,
  output logic [2:0]    phase,
  output logic          correct,
  output logic          wrong,
  output logic [7:0]    score,
  output logic [3:0]    lives,
  output logic          game_over
);

  localparam int TMAX = (SHOW_TICKS > ENTRY_TIMEOUT) ? SHOW_TICKS : ENTRY_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SHOW, ENTER, CHECK, RESULT, OVER
  } stateT;

  stateT         state, stateNext;
  logic [W-1:0]  target, targetNext;
  logic [W-1:0]  entry, entryNext;
  logic [TW-1:0] tickCnt, tickNext;
  logic          roundPass, passNext;
  logic [W-1:0]  lenMask;
  logic [W-1:0]  showValueNext;
  logic [LW-1:0] showLenNext, entryCntNext;
  logic [7:0]    scoreNext;
  logic [3:0]    livesNext;
  logic [2:0]    phaseNext;
  logic          correctNext, wrongNext;
  logic          goResult, resultPass;

  // Nibble mask selecting the digits that are active in the current round.
  always_comb begin
    lenMask = '0;
    for (int i = 0; i < DIGITS_MAX; i++) begin
      lenMask[4*i +: 4] = (i < int'(show_len)) ? 4'hF : 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      target     <= '0;
      entry      <= '0;
      tickCnt    <= '0;
      roundPass  <= 1'b0;
      show_value <= '0;
      show_len   <= LW'(DIGITS_START);
      entry_cnt  <= '0;
      phase      <= 3'd0;
      correct    <= 1'b0;
      wrong      <= 1'b0;
      score      <= 8'd0;
      lives      <= 4'(LIVES);
      game_over  <= 1'b0;
    end else begin
      state      <= stateNext;
      target     <= targetNext;
      entry      <= entryNext;
      tickCnt    <= tickNext;
      roundPass  <= passNext;
      show_value <= showValueNext;
      show_len   <= showLenNext;
      entry_cnt  <= entryCntNext;
      phase      <= phaseNext;
      correct    <= correctNext;
      wrong      <= wrongNext;
      score      <= scoreNext;
      lives      <= livesNext;
      game_over  <= (stateNext == OVER);
    end
  end

  always_comb begin
    stateNext    = state;
    targetNext   = target;
    entryNext    = entry;
    tickNext     = tickCnt;
    passNext     = roundPass;
    showLenNext  = show_len;
    entryCntNext = entry_cnt;
    scoreNext    = score;
    livesNext    = lives;
    correctNext  = 1'b0;
    wrongNext    = 1'b0;
    goResult     = 1'b0;
    resultPass   = 1'b0;

    case (state)
      IDLE: begin
        if (start) stateNext = LOAD;
      end
      LOAD: begin
        targetNext   = rand_in & lenMask;
        entryNext    = '0;
        entryCntNext = '0;
        tickNext     = '0;
        stateNext    = SHOW;
      end
      SHOW: begin
        if (tick) begin
          if (tickCnt == TW'(SHOW_TICKS - 1)) begin
            tickNext  = '0;
            stateNext = ENTER;
          end else begin
            tickNext = tickCnt + TW'(1);
          end
        end
      end
      // A valid key takes priority over a coincident tick and restarts the timeout.
      ENTER: begin
        if (key_valid && (key_digit <= 4'd9)) begin
          entryNext    = {entry[W-5:0], key_digit};
          entryCntNext = entry_cnt + LW'(1);
          tickNext     = '0;
          if (entryCntNext == show_len) stateNext = CHECK;
        end else if (tick) begin
          if (tickCnt == TW'(ENTRY_TIMEOUT - 1)) begin
            goResult   = 1'b1;
            resultPass = 1'b0;
          end else begin
            tickNext = tickCnt + TW'(1);
          end
        end
      end
      CHECK: begin
        goResult   = 1'b1;
        resultPass = (((entry ^ target) & lenMask) == '0);
      end
      RESULT: begin
        stateNext = (roundPass || (lives != 4'd0)) ? LOAD : OVER;
      end
      OVER: begin
        if (start) begin
          scoreNext   = 8'd0;
          livesNext   = 4'(LIVES);
          showLenNext = LW'(DIGITS_START);
          stateNext   = LOAD;
        end
      end
      default: stateNext = IDLE;
    endcase

    // Score, lives and round length update on the same edge that raises the pulse.
    if (goResult) begin
      stateNext = RESULT;
      passNext  = resultPass;
      if (resultPass) begin
        correctNext = 1'b1;
        scoreNext   = (score == 8'd255) ? score : score + 8'd1;
        showLenNext = (show_len == LW'(DIGITS_MAX)) ? show_len : show_len + LW'(1);
      end else begin
        wrongNext = 1'b1;
        livesNext = (lives == 4'd0) ? lives : lives - 4'd1;
      end
    end
  end

  always_comb begin
    showValueNext = show_value;
    phaseNext     = phase;
    case (stateNext)
      IDLE:   begin showValueNext = '0;         phaseNext = 3'd0; end
      LOAD:   phaseNext = 3'd1;
      SHOW:   begin showValueNext = targetNext; phaseNext = 3'd1; end
      ENTER:  begin showValueNext = entryNext;  phaseNext = 3'd2; end
      CHECK:  phaseNext = 3'd3;
      RESULT: phaseNext = 3'd3;
      OVER:   begin showValueNext = targetNext; phaseNext = 3'd4; end
      default: phaseNext = 3'd0;
    endcase
  end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed bench for memory_game_ctrl: pass/fail rounds, timeout, game over,
// length saturation and reset in the middle of an entry.
module tb_memory_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, start, key_valid;
  logic [31:0] rand_in;
  logic [3:0]  key_digit;
  logic [31:0] show_value;
  logic [3:0]  show_len, entry_cnt, lives;
  logic [2:0]  phase;
  logic        correct, wrong, game_over;
  logic [7:0]  score;

  int checks = 0;
  int errors = 0;
  int modelScore, modelLives, modelLen;

  memory_game_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .rand_in(rand_in),
    .key_valid(key_valid), .key_digit(key_digit), .show_value(show_value),
    .show_len(show_len), .entry_cnt(entry_cnt), .phase(phase), .correct(correct),
    .wrong(wrong), .score(score), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic t, input logic s, input logic kv,
                               input logic [3:0] kd);
    tick = t; start = s; key_valid = kv; key_digit = kd;
    @(posedge clk); #1;
    tick = 1'b0; start = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
  endtask

  function automatic logic [31:0] expTarget(input int len);
    logic [31:0] t;
    t = '0;
    for (int i = 0; i < len; i++) t[4*i +: 4] = rand_in[4*i +: 4];
    return t;
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_phase"}, 32'(phase), 32'd0);
    checkOutput({tag, "_show"}, show_value, 32'd0);
    checkOutput({tag, "_entryCnt"}, 32'(entry_cnt), 32'd0);
    checkOutput({tag, "_score"}, 32'(score), 32'd0);
    checkOutput({tag, "_lives"}, 32'(lives), 32'd3);
    checkOutput({tag, "_showLen"}, 32'(show_len), 32'd4);
    checkOutput({tag, "_pulses"}, {30'd0, correct, wrong}, 32'd0);
    checkOutput({tag, "_gameOver"}, 32'(game_over), 32'd0);
  endtask

  task automatic showPhase(input int len);
    applyStimulus(0, 0, 0, 4'd0);
    checkOutput("showTarget", show_value, expTarget(len));
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 4'd0);
    checkOutput("enterPhase", 32'(phase), 32'd2);
  endtask

  // Called with the DUT in LOAD; leaves it in LOAD again or in OVER.
  task automatic runRound(input int len, input bit good);
    logic [3:0] d;
    showPhase(len);
    for (int i = len - 1; i >= 0; i--) begin
      d = rand_in[4*i +: 4];
      if (!good && i == 0) d = (d == 4'd9) ? 4'd0 : d + 4'd1;
      applyStimulus(0, 0, 1, d);
    end
    checkOutput("entryCntFull", 32'(entry_cnt), 32'(len));
    checkOutput("noEarlyPulse", {30'd0, correct, wrong}, 32'd0);
    applyStimulus(0, 0, 0, 4'd0);
    if (good) begin
      modelScore = modelScore + 1;
      if (modelLen < 8) modelLen = modelLen + 1;
    end else begin
      modelLives = modelLives - 1;
    end
    checkOutput("correctPulse", 32'(correct), 32'(good));
    checkOutput("wrongPulse", 32'(wrong), 32'(!good));
    checkOutput("score", 32'(score), 32'(modelScore));
    checkOutput("lives", 32'(lives), 32'(modelLives));
    checkOutput("showLen", 32'(show_len), 32'(modelLen));
    applyStimulus(0, 0, 0, 4'd0);
    checkOutput("pulseCleared", {30'd0, correct, wrong}, 32'd0);
    checkOutput("gameOver", 32'(game_over), 32'(modelLives == 0));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; tick = 0; start = 0; key_valid = 0; key_digit = 0;
    rand_in = 32'h9876_1234;
    modelScore = 0; modelLives = 3; modelLen = 4;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkResetValues("reset");

    // Inputs other than start are ignored in IDLE.
    applyStimulus(1, 0, 1, 4'd3);
    checkOutput("idleIgnore", 32'(phase), 32'd0);

    // Round 1: target 1234 with a stray key in SHOW and an invalid key mid-entry.
    applyStimulus(0, 1, 0, 4'd0);
    applyStimulus(0, 0, 0, 4'd0);
    checkOutput("r1Show", show_value, 32'h0000_1234);
    checkOutput("r1Phase", 32'(phase), 32'd1);
    applyStimulus(0, 0, 1, 4'd5);
    checkOutput("keyInShow", 32'(entry_cnt), 32'd0);
    applyStimulus(1, 0, 0, 4'd0);
    applyStimulus(1, 0, 0, 4'd0);
    checkOutput("twoTicksStillShow", 32'(phase), 32'd1);
    applyStimulus(1, 0, 0, 4'd0);
    checkOutput("thirdTickEnter", 32'(phase), 32'd2);
    checkOutput("entryCleared", show_value, 32'd0);
    applyStimulus(0, 0, 1, 4'd1);
    applyStimulus(0, 0, 1, 4'd2);
    checkOutput("entryShift", show_value, 32'h0000_0012);
    applyStimulus(0, 0, 1, 4'hA);
    checkOutput("keyAIgnored", 32'(entry_cnt), 32'd2);
    applyStimulus(0, 0, 1, 4'd3);
    applyStimulus(0, 0, 1, 4'd4);
    checkOutput("r1NoPulseYet", 32'(correct), 32'd0);
    applyStimulus(0, 0, 0, 4'd0);
    checkOutput("r1Correct", 32'(correct), 32'd1);
    checkOutput("r1Score", 32'(score), 32'd1);
    checkOutput("r1ShowLen", 32'(show_len), 32'd5);
    modelScore = 1; modelLen = 5;
    applyStimulus(0, 0, 0, 4'd0);
    checkOutput("r1PulseOnce", 32'(correct), 32'd0);

    // Wrong digit: lives drop, length stays.
    runRound(5, 0);

    // Timeout: a key coinciding with a tick restarts the count; invalid keys do not.
    showPhase(5);
    for (int i = 0; i < 19; i++) applyStimulus(1, 0, 0, 4'd0);
    applyStimulus(1, 0, 1, 4'd6);
    checkOutput("keyBeatsTick", 32'(entry_cnt), 32'd1);
    checkOutput("noTimeoutYet", 32'(wrong), 32'd0);
    for (int i = 0; i < 19; i++) applyStimulus(1, 0, 0, 4'd0);
    checkOutput("tick19NoWrong", 32'(wrong), 32'd0);
    applyStimulus(0, 0, 1, 4'hB);
    checkOutput("keyBNoCount", 32'(entry_cnt), 32'd1);
    applyStimulus(1, 0, 0, 4'd0);
    modelLives = modelLives - 1;
    checkOutput("timeoutWrong", 32'(wrong), 32'd1);
    checkOutput("timeoutLives", 32'(lives), 32'(modelLives));
    applyStimulus(0, 0, 0, 4'd0);

    // Third failure ends the game.
    runRound(5, 0);
    checkOutput("overPhase", 32'(phase), 32'd4);
    checkOutput("overShow", show_value, expTarget(5));
    applyStimulus(0, 0, 1, 4'd1);
    checkOutput("overKeyIgnored", 32'(phase), 32'd4);
    applyStimulus(0, 1, 0, 4'd0);
    modelScore = 0; modelLives = 3; modelLen = 4;
    checkOutput("restartLives", 32'(lives), 32'd3);
    checkOutput("restartScore", 32'(score), 32'd0);
    checkOutput("restartLen", 32'(show_len), 32'd4);
    checkOutput("restartGameOver", 32'(game_over), 32'd0);

    // Pass up to 8 digits, then once more to confirm saturation.
    runRound(4, 1);
    runRound(5, 1);
    runRound(6, 1);
    runRound(7, 1);
    runRound(8, 1);
    runRound(8, 1);
    checkOutput("lenSaturated", 32'(show_len), 32'd8);

    // Reset in the middle of an entry.
    showPhase(8);
    applyStimulus(0, 0, 1, 4'd9);
    applyStimulus(0, 0, 1, 4'd8);
    checkOutput("midEntryCnt", 32'(entry_cnt), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    checkResetValues("midReset");
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
